bf_uart_io: RTL and testbench
=============================

# bf_uart_io

UART access controller for the bfCPU: converts the core's '.' (output byte) and ',' (input byte) requests into polled transactions on the UART's IO bus. It sits directly upstream of the UART and is the only master of its IO_REQ/IO_WRITE/IO_ADDR/IO_WDATA bus. After reset it programs the baud divider registers, then serves one CPU request at a time, polling UART status before each data access.

## Interface
Parameters:
- DIV0_INIT, 8'h02, value written to UART DIV0 (addr 2'b10) after reset
- DIV1_INIT, 8'h03, value written to UART DIV1 (addr 2'b11) after reset

Ports:
- CLK  in  1  clock; all state on rising edge
- RES  in  1  reset, synchronous, active-high
- OUT_REQ  in  1  CPU output request; level, held until OUT_ACK
- OUT_DATA  in  8  byte to transmit; stable while OUT_REQ
- OUT_ACK  out  1  one-cycle pulse: byte written into UART TX FIFO
- IN_REQ  in  1  CPU input request; level, held until IN_ACK
- IN_DATA  out  8  last received byte; valid from IN_ACK until next IN_ACK
- IN_ACK  out  1  one-cycle pulse: IN_DATA updated
- INIT_DONE  out  1  high once divider writes complete
- IO_REQ  out  1  UART bus command valid (address phase)
- IO_WRITE  out  1  1 = write, 0 = read
- IO_ADDR  out  2  00 data, 01 status, 10 DIV0, 11 DIV1
- IO_WDATA  out  8  write data
- IO_RDATA  in  8  read data, valid in read data phase
- IO_RDY  in  1  UART ready; advances address and data phases

## Operation
- UART bus: address phase completes on a cycle with IO_REQ=1 and IO_RDY=1; the next cycle(s) are its data phase, completing on the first cycle with IO_RDY=1. Read data sampled from IO_RDATA at that edge. The bridge never overlaps: IO_REQ=0 during data phases.
- UART status register (addr 01): bit0 = RX FIFO not empty, bit1 = TX FIFO full; other bits ignored.
- States: I0A, I0D (write DIV0), I1A, I1D (write DIV1), IDLE, TSA, TSD (read status for TX), TWA, TWD (write data), RSA, RSD (read status for RX), RRA, RRD (read data), OACK, IACK.
- Reset → I0A. I0A→I0D→I1A→I1D→IDLE, each on IO_RDY. INIT_DONE set on entering IDLE, stays 1 until reset.
- IDLE: OUT_REQ → TSA; else IN_REQ → RSA; OUT has priority when both high.
- TSD on IO_RDY: status bit1=1 → TSA (re-poll); else → TWA. TWA drives IO_WRITE=1, IO_ADDR=00, IO_WDATA=OUT_DATA (latched on leaving IDLE). TWD on IO_RDY → OACK.
- RSD on IO_RDY: bit0=0 → RSA; else → RRA. RRD on IO_RDY: IN_DATA ← IO_RDATA → IACK.
- OACK/IACK: ack output high for exactly this one cycle → IDLE. Requests are not sampled in OACK/IACK, so a REQ still high during its ACK cycle does not start a new transaction.
- Requests arriving during init are held off until IDLE; no request is dropped.
- Polling is unbounded; no timeout.

## Timing
- Reset values: IO_REQ=0, IO_WRITE=0, IO_ADDR=2'b00, IO_WDATA=8'h00, OUT_ACK=0, IN_ACK=0, IN_DATA=8'h00, INIT_DONE=0.
- All outputs are registered or decoded from the state register only; no combinational path from IO_RDY/IO_RDATA/OUT_REQ/IN_REQ to outputs.
- IO_REQ=1 only in I0A, I1A, TSA, TWA, RSA, RRA. IO_WRITE/IO_ADDR/IO_WDATA held stable through the data phase.
- Init with IO_RDY=1: INIT_DONE high 4 cycles after RES deassertion edge.
- OUT with IO_RDY=1, TX not full: REQ sampled in IDLE at edge n → OUT_ACK high in cycle n+5. Each TX-full poll adds 2 cycles. IN identical latency, gated by RX empty.
- Each IO_RDY=0 cycle in any phase adds exactly one cycle.
- RES asserted mid-transaction: next edge → I0A, IO_REQ=0, acks 0, pending transaction abandoned; divider writes redone.

## Test plan
- Init: IO_RDY=1 → writes 8'h02 to addr 10, 8'h03 to addr 11 in order, INIT_DONE after 4 cycles; no further IO_REQ while idle.
- Loopback TX/RX with UART model, OUT_DATA=8'h89 then IN_REQ → one data write of 8'h89, OUT_ACK at +5 cycles; IN_DATA=8'h89 with single IN_ACK pulse.
- TX full: status returns 8'h02 three times then 8'h00 → exactly 4 status reads, then one write, OUT_ACK once.
- RX empty then data 8'hab: status 8'h00 ×5, then 8'h01 → one data read, IN_DATA=8'hab; OUT_REQ and IN_REQ raised together → output served first.
- IO_RDY stalls: random IO_RDY=0 in every phase → command fields stable, no duplicate write, ack count equals request count.
- Reset during TWD → IO_REQ low next cycle, no OUT_ACK, divider writes re-issued, subsequent OUT 8'h55 completes normally.

Source files
------------

// File: rtl/bf_uart_io.sv
// rtl/bf_uart_io.sv - polled UART bus master serving bfCPU '.' and ',' byte requests
module bf_uart_io #(
    parameter logic [7:0] DIV0_INIT = 8'h02,
    parameter logic [7:0] DIV1_INIT = 8'h03
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       OUT_REQ,
    input  logic [7:0] OUT_DATA,
    output logic       OUT_ACK,
    input  logic       IN_REQ,
    output logic [7:0] IN_DATA,
    output logic       IN_ACK,
    output logic       INIT_DONE,
    output logic       IO_REQ,
    output logic       IO_WRITE,
    output logic [1:0] IO_ADDR,
    output logic [7:0] IO_WDATA,
    input  logic [7:0] IO_RDATA,
    input  logic       IO_RDY
);

    typedef enum logic [3:0] {
        I0A, I0D, I1A, I1D, IDLE,
        TSA, TSD, TWA, TWD,
        RSA, RSD, RRA, RRD,
        OACK, IACK
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'b00;
    localparam logic [1:0] ADDR_STAT = 2'b01;
    localparam logic [1:0] ADDR_DIV0 = 2'b10;
    localparam logic [1:0] ADDR_DIV1 = 2'b11;

    state_t     state;
    state_t     nx_state;
    logic [7:0] tx_byte;
    logic       addr_done;
    logic       nx_req;
    logic       nx_write;
    logic [1:0] nx_addr;
    logic [7:0] nx_wdata;

    // Address phase only completes while our registered IO_REQ is actually up;
    // this keeps the first cycle after reset (IO_REQ still 0) from counting.
    assign addr_done = IO_REQ & IO_RDY;

    always_comb begin
        nx_state = state;
        case (state)
            I0A:  if (addr_done) nx_state = I0D;
            I0D:  if (IO_RDY)    nx_state = I1A;
            I1A:  if (addr_done) nx_state = I1D;
            I1D:  if (IO_RDY)    nx_state = IDLE;
            IDLE: begin
                if (OUT_REQ)     nx_state = TSA;
                else if (IN_REQ) nx_state = RSA;
            end
            TSA:  if (addr_done) nx_state = TSD;
            TSD:  if (IO_RDY)    nx_state = IO_RDATA[1] ? TSA : TWA;
            TWA:  if (addr_done) nx_state = TWD;
            TWD:  if (IO_RDY)    nx_state = OACK;
            RSA:  if (addr_done) nx_state = RSD;
            RSD:  if (IO_RDY)    nx_state = IO_RDATA[0] ? RRA : RSA;
            RRA:  if (addr_done) nx_state = RRD;
            RRD:  if (IO_RDY)    nx_state = IACK;
            OACK: nx_state = IDLE;
            IACK: nx_state = IDLE;
            default: nx_state = I0A;
        endcase
    end

    // Bus command decoded from the next state, so each command is registered
    // and held unchanged across its address and data phase pair.
    always_comb begin
        nx_req   = 1'b0;
        nx_write = 1'b0;
        nx_addr  = ADDR_DATA;
        nx_wdata = 8'h00;
        case (nx_state)
            I0A, I0D: begin
                nx_req   = (nx_state == I0A);
                nx_write = 1'b1;
                nx_addr  = ADDR_DIV0;
                nx_wdata = DIV0_INIT;
            end
            I1A, I1D: begin
                nx_req   = (nx_state == I1A);
                nx_write = 1'b1;
                nx_addr  = ADDR_DIV1;
                nx_wdata = DIV1_INIT;
            end
            TSA, TSD, RSA, RSD: begin
                nx_req   = (nx_state == TSA) || (nx_state == RSA);
                nx_addr  = ADDR_STAT;
            end
            TWA, TWD: begin
                nx_req   = (nx_state == TWA);
                nx_write = 1'b1;
                nx_addr  = ADDR_DATA;
                nx_wdata = tx_byte;
            end
            RRA, RRD: begin
                nx_req   = (nx_state == RRA);
                nx_addr  = ADDR_DATA;
            end
            default: begin
                nx_req   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            state     <= I0A;
            IO_REQ    <= 1'b0;
            IO_WRITE  <= 1'b0;
            IO_ADDR   <= ADDR_DATA;
            IO_WDATA  <= 8'h00;
            OUT_ACK   <= 1'b0;
            IN_ACK    <= 1'b0;
            IN_DATA   <= 8'h00;
            INIT_DONE <= 1'b0;
            tx_byte   <= 8'h00;
        end else begin
            state    <= nx_state;
            IO_REQ   <= nx_req;
            IO_WRITE <= nx_write;
            IO_ADDR  <= nx_addr;
            IO_WDATA <= nx_wdata;
            OUT_ACK  <= (nx_state == OACK);
            IN_ACK   <= (nx_state == IACK);
            if (nx_state == IDLE)
                INIT_DONE <= 1'b1;
            if (state == IDLE && OUT_REQ)
                tx_byte <= OUT_DATA;
            if (state == RRD && IO_RDY)
                IN_DATA <= IO_RDATA;
        end
    end

endmodule

// File: tb/tb_bf_uart_io.sv
// tb/tb_bf_uart_io.sv - scoreboard bench for bf_uart_io with a loopback UART target model
module tb_bf_uart_io;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic       OUT_REQ = 1'b0;
    logic [7:0] OUT_DATA = 8'h00;
    logic       OUT_ACK;
    logic       IN_REQ = 1'b0;
    logic [7:0] IN_DATA;
    logic       IN_ACK;
    logic       INIT_DONE;
    logic       IO_REQ;
    logic       IO_WRITE;
    logic [1:0] IO_ADDR;
    logic [7:0] IO_WDATA;
    logic [7:0] IO_RDATA = 8'h00;
    logic       IO_RDY = 1'b1;

    bf_uart_io dut (
        .CLK(CLK), .RES(RES),
        .OUT_REQ(OUT_REQ), .OUT_DATA(OUT_DATA), .OUT_ACK(OUT_ACK),
        .IN_REQ(IN_REQ), .IN_DATA(IN_DATA), .IN_ACK(IN_ACK),
        .INIT_DONE(INIT_DONE),
        .IO_REQ(IO_REQ), .IO_WRITE(IO_WRITE), .IO_ADDR(IO_ADDR),
        .IO_WDATA(IO_WDATA), .IO_RDATA(IO_RDATA), .IO_RDY(IO_RDY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         kind;   // 0 bus write, 1 OUT_ACK, 2 IN_ACK
        logic [1:0] addr;
        logic [7:0] data;
        int         lat;    // cycles from request raise to ack, -1 = unchecked
    } exp_t;

    exp_t       exp_q[$];
    exp_t       e_m;
    logic [7:0] ref_rx[$];
    logic [7:0] uart_rx[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int req_cyc = 0;
    int acks = 0;
    int reqs = 0;
    int stat_reads = 0;
    int data_writes = 0;
    int addr_phases = 0;
    int tx_full_polls = 0;
    int rx_empty_polls = 0;
    int stall_pct = 0;
    bit hold_dwrite = 0;

    bit         dphase = 0;
    logic       c_write = 0;
    logic [1:0] c_addr = 0;
    logic [7:0] c_wdata = 0;
    logic       p_req = 0, p_write = 0, p_rdy = 0;
    logic [1:0] p_addr = 0;
    logic [7:0] p_wdata = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push_exp(input int k, input logic [1:0] a, input logic [7:0] d, input int l);
        exp_t x;
        x.kind = k; x.addr = a; x.data = d; x.lat = l;
        exp_q.push_back(x);
    endfunction

    // UART target model and output monitor. Each negedge first settles the
    // rising edge that just passed (using what was on the bus then), then
    // checks current outputs and drives IO_RDY/IO_RDATA for the next edge.
    always @(negedge CLK) begin
        if (RES) begin
            dphase = 0;
            p_req = 0; p_rdy = 0;
            IO_RDY = 1'b1;
        end else begin
            if (!dphase) begin
                if (p_req && p_rdy) begin
                    dphase = 1; c_write = p_write; c_addr = p_addr; c_wdata = p_wdata;
                    addr_phases++;
                end
            end else if (p_rdy) begin
                dphase = 0;
                if (c_write) begin
                    if (c_addr == 2'b00) begin
                        data_writes++;
                        uart_rx.push_back(c_wdata);
                    end
                    if (exp_q.size() == 0) check("unexpected_write", {c_addr, c_wdata}, 32'hffff);
                    else begin
                        e_m = exp_q.pop_front();
                        check("write_kind", e_m.kind, 0);
                        check("write_addr_data", {c_addr, c_wdata}, {e_m.addr, e_m.data});
                    end
                end else if (c_addr == 2'b01) begin
                    stat_reads++;
                    if (tx_full_polls > 0) tx_full_polls--;
                    if (rx_empty_polls > 0) rx_empty_polls--;
                end else if (c_addr == 2'b00 && uart_rx.size() > 0) begin
                    void'(uart_rx.pop_front());
                end
            end

            if (dphase) begin
                check("dphase_io_req", IO_REQ, 0);
                check("dphase_cmd_stable", {IO_WRITE, IO_ADDR, IO_WDATA}, {c_write, c_addr, c_wdata});
            end
            if (OUT_ACK) begin
                acks++;
                if (exp_q.size() == 0) check("unexpected_out_ack", 1, 0);
                else begin
                    e_m = exp_q.pop_front();
                    check("out_ack_order", e_m.kind, 1);
                    if (e_m.lat >= 0) check("out_ack_latency", cyc - req_cyc, e_m.lat);
                end
            end
            if (IN_ACK) begin
                acks++;
                if (exp_q.size() == 0) check("unexpected_in_ack", 1, 0);
                else begin
                    e_m = exp_q.pop_front();
                    check("in_ack_order", e_m.kind, 2);
                    check("in_data", IN_DATA, e_m.data);
                    if (e_m.lat >= 0) check("in_ack_latency", cyc - req_cyc, e_m.lat);
                end
            end

            IO_RDY = (stall_pct == 0) || ($urandom_range(0, 99) >= stall_pct);
            if (hold_dwrite && dphase && c_write && c_addr == 2'b00) IO_RDY = 1'b0;
            if (dphase && !c_write) begin
                if (c_addr == 2'b01)
                    IO_RDATA = {6'b0, tx_full_polls > 0, (uart_rx.size() > 0) && (rx_empty_polls == 0)};
                else
                    IO_RDATA = (uart_rx.size() > 0) ? uart_rx[0] : 8'hee;
            end else begin
                IO_RDATA = 8'h00;
            end
            p_req = IO_REQ; p_write = IO_WRITE; p_addr = IO_ADDR; p_wdata = IO_WDATA; p_rdy = IO_RDY;
        end
    end

    // Reference: bytes come back in the order they were sent (loopback UART).
    task automatic run_req(input bit o, input bit i, input logic [7:0] b, input int olat, input int ilat);
        bit op, ip;
        int t;
        logic [7:0] d;
        op = o; ip = i; t = 0;
        if (o) begin
            push_exp(0, 2'b00, b, -1);
            push_exp(1, 2'b00, 8'h00, olat);
            ref_rx.push_back(b);
            reqs++;
        end
        if (i) begin
            d = ref_rx.pop_front();
            push_exp(2, 2'b00, d, ilat);
            reqs++;
        end
        OUT_DATA = b; OUT_REQ = o; IN_REQ = i; req_cyc = cyc;
        while ((op || ip || OUT_REQ || IN_REQ) && t < 3000) begin
            @(negedge CLK);
            t++;
            if (!op) OUT_REQ = 1'b0;
            if (!ip) IN_REQ = 1'b0;
            if (op && OUT_ACK) op = 0;
            if (ip && IN_ACK) ip = 0;
        end
        if (t >= 3000) begin
            check("request_timeout", 1, 0);
            OUT_REQ = 1'b0; IN_REQ = 1'b0;
        end
    endtask

    task automatic release_reset();
        exp_q.delete();
        push_exp(0, 2'b10, 8'h02, -1);
        push_exp(0, 2'b11, 8'h03, -1);
        RES = 1'b0;
    endtask

    initial begin
        int s0, d0, t, op, tp, rp;
        logic [7:0] b;

        repeat (3) @(negedge CLK);
        check("reset_outputs", {IO_REQ, IO_WRITE, IO_ADDR, IO_WDATA, OUT_ACK, IN_ACK, IN_DATA, INIT_DONE}, 0);
        release_reset();
        repeat (4) @(negedge CLK);
        check("init_done_early", INIT_DONE, 0);
        @(negedge CLK);
        check("init_done_4_cycles", INIT_DONE, 1);
        repeat (10) @(negedge CLK);
        check("init_addr_phases", addr_phases, 2);
        check("init_writes_seen", exp_q.size(), 0);

        d0 = data_writes;
        run_req(1, 0, 8'h89, 5, -1);
        run_req(0, 1, 8'h00, -1, 5);
        check("loopback_one_write", data_writes - d0, 1);

        tx_full_polls = 3; rx_empty_polls = 0;
        s0 = stat_reads; d0 = data_writes;
        run_req(1, 0, 8'h5a, 5 + 2 * 3, -1);
        check("tx_full_status_reads", stat_reads - s0, 4);
        check("tx_full_one_write", data_writes - d0, 1);
        run_req(0, 1, 8'h00, -1, 5);

        uart_rx.push_back(8'hab); ref_rx.push_back(8'hab);
        tx_full_polls = 0; rx_empty_polls = 5;
        s0 = stat_reads;
        run_req(0, 1, 8'h00, -1, 5 + 2 * 5);
        check("rx_empty_status_reads", stat_reads - s0, 6);

        run_req(1, 1, 8'h3c, 5, -1);

        for (int k = 0; k < 30; k++) begin
            stall_pct = (k < 5) ? 0 : $urandom_range(0, 50);
            op = $urandom_range(0, 2);
            b = 8'($urandom);
            tp = (op != 1) ? $urandom_range(0, 3) : 0;
            rp = (op == 1) ? $urandom_range(0, 3) : 0;
            tx_full_polls = tp; rx_empty_polls = rp;
            if (op == 1 && ref_rx.size() == 0) begin
                uart_rx.push_back(b ^ 8'h5f); ref_rx.push_back(b ^ 8'h5f);
            end
            if (op == 0)      run_req(1, 0, b, (stall_pct == 0) ? 5 + 2 * tp : -1, -1);
            else if (op == 1) run_req(0, 1, b, -1, (stall_pct == 0) ? 5 + 2 * rp : -1);
            else              run_req(1, 1, b, (stall_pct == 0) ? 5 + 2 * tp : -1, -1);
        end
        stall_pct = 0;
        repeat (3) @(negedge CLK);

        hold_dwrite = 1; tx_full_polls = 0; rx_empty_polls = 0;
        OUT_DATA = 8'hc3; OUT_REQ = 1'b1;
        t = 0;
        while (!(dphase && c_write && c_addr == 2'b00) && t < 100) begin
            @(negedge CLK); t++;
        end
        check("reached_data_write_phase", t < 100, 1);
        repeat (2) @(negedge CLK);
        RES = 1'b1;
        @(negedge CLK);
        check("reset_io_req_low", IO_REQ, 0);
        check("reset_no_out_ack", OUT_ACK, 0);
        OUT_REQ = 1'b0; hold_dwrite = 0;
        @(negedge CLK);
        d0 = data_writes; s0 = addr_phases;
        release_reset();
        t = 0;
        while (!INIT_DONE && t < 50) begin
            @(negedge CLK); t++;
        end
        check("reinit_done", INIT_DONE, 1);
        check("reinit_divider_phases", addr_phases - s0, 2);
        run_req(1, 0, 8'h55, 5, -1);
        check("post_reset_one_write", data_writes - d0, 1);
        run_req(0, 1, 8'h00, -1, 5);

        repeat (10) @(negedge CLK);
        check("scoreboard_drained", exp_q.size(), 0);
        check("ack_count", acks, reqs);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
